// File: rtl/top_hp.sv
// top_hp: pulse-width meter.
// Counts the SYS_CLK edges at which the sampled PULSE level is high and
// publishes the count on OUT_REG when the pulse ends. The count saturates
// at 2^CNT_W-1 and does not wrap.
// Build option: define TOP_HP_SYNC_EN to add a two-flop synchronizer in
// front of edge detection. This suits a PULSE that is asynchronous to
// SYS_CLK. The measured width does not change; only the latency grows by
// two cycles.
module top_hp #(
   parameter int CNT_W = 5
) (
   input  logic             SYS_CLK,
   input  logic             A_RESET,
   input  logic             PULSE,
   output logic [CNT_W-1:0] OUT_REG
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Increment that sticks at full scale, so long pulses report the maximum.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CNT_MAX) begin
         return CNT_MAX;
      end
      return v + CNT_W'(1);
   endfunction

   logic             p_s;
   logic             p_d;
   logic             rise;
   logic             hold;
   logic             fall;
   logic [CNT_W-1:0] cnt;

`ifdef TOP_HP_SYNC_EN
   logic sync_p0;
   logic sync_p1;

   // Two-flop synchronizer that brings the asynchronous PULSE into the SYS_CLK domain.
   always_ff @(posedge SYS_CLK or negedge A_RESET) begin
      if (!A_RESET) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= PULSE;
         sync_p1 <= sync_p0;
      end
   end

   assign p_s = sync_p1;
`else
   assign p_s = PULSE;
`endif

   assign rise = p_s & ~p_d;
   assign hold = p_s & p_d;
   assign fall = ~p_s & p_d;

   // Delayed copy of the sampled level, used for edge detection.
   always_ff @(posedge SYS_CLK or negedge A_RESET) begin
      if (!A_RESET) begin
         p_d <= 1'b0;
      end else begin
         p_d <= p_s;
      end
   end

   // Width counter: starts at 1 on a rise, saturates while high, and is dumped into OUT_REG on a fall.
   always_ff @(posedge SYS_CLK or negedge A_RESET) begin
      if (!A_RESET) begin
         cnt     <= '0;
         OUT_REG <= '0;
      end else if (rise) begin
         cnt <= CNT_W'(1);
      end else if (hold) begin
         cnt <= sat_inc(cnt);
      end else if (fall) begin
         OUT_REG <= cnt;
         cnt     <= '0;
      end else begin
         cnt <= '0;
      end
   end

endmodule

// File: tb/tb_top_hp.sv
// Testbench for top_hp: directed scenarios plus randomized pulse trains.
// The reference model is a run-length measurer working on the sampled
// PULSE history.
`timescale 1ns/1ps
module tb_top_hp;

`ifdef TOP_HP_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic       sys_clk;
   logic       a_reset;
   logic       pulse;
   logic [4:0] out_reg;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   top_hp #(.CNT_W(5)) dut (
      .SYS_CLK (sys_clk),
      .A_RESET (a_reset),
      .PULSE   (pulse),
      .OUT_REG (out_reg)
   );

   initial begin
      sys_clk = 1'b0;
      forever #50 sys_clk = ~sys_clk;
   end

   // Reference model: the level seen by the measurer is PULSE delayed by LAT edges.
   // The model counts the length of each high run and reports min(run, 31) when the run ends.
   logic       hist0, hist1, s_m;
   int         run;
   logic [4:0] m_out;

   assign s_m = (LAT == 0) ? pulse : hist1;

   always @(posedge sys_clk or negedge a_reset) begin
      if (!a_reset) begin
         hist0 <= 1'b0;
         hist1 <= 1'b0;
         run   <= 0;
         m_out <= 5'd0;
      end else begin
         hist0 <= pulse;
         hist1 <= hist0;
         if (s_m) begin
            run <= run + 1;
         end else begin
            if (run > 0) m_out <= (run > 31) ? 5'd31 : 5'(run);
            run <= 0;
         end
      end
   end

   // Advance n cycles, landing 30 ns after a rising edge.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #30;
      end
   endtask

   task automatic test_reset;
      a_reset = 1'b0;
      pulse   = 1'b0;
      #1;
      chk_cnt++;
      if (out_reg !== 5'd0) $display("FAIL reset_t1: got %0d expected 0", out_reg);
      else pass_cnt++;
      #59;
      chk_cnt++;
      if (out_reg !== 5'd0) $display("FAIL reset_t60: got %0d expected 0", out_reg);
      else pass_cnt++;
      #40;
      a_reset = 1'b1;
      #20;
      chk_cnt++;
      if (out_reg !== 5'd0) $display("FAIL reset_release: got %0d expected 0", out_reg);
      else pass_cnt++;
      #50;
      chk_cnt++;
      if (out_reg !== 5'd0) $display("FAIL reset_idle: got %0d expected 0", out_reg);
      else pass_cnt++;
   endtask

   task automatic test_normal;
      fork
         begin
            #(64'd200 - $time);
            pulse = 1'b1; #800;
            pulse = 1'b0; #500;
            pulse = 1'b1; #1200;
            pulse = 1'b0; #400;
            pulse = 1'b1; #1800;
            pulse = 1'b0;
         end
         begin
            for (int c = 0; c < 54; c++) begin
               @(posedge sys_clk);
               #25;
               chk_cnt++;
               if (out_reg !== m_out) $display("FAIL normal_model t=%0t: got %0d expected %0d", $time, out_reg, m_out);
               else pass_cnt++;
               if ($time == 64'd1175) begin
                  chk_cnt++;
                  if (out_reg !== ((LAT == 0) ? 5'd8 : 5'd0))
                     $display("FAIL normal_latency: got %0d expected %0d", out_reg, (LAT == 0) ? 8 : 0);
                  else pass_cnt++;
               end
               if ($time == 64'd1375 || $time == 64'd2575) begin
                  chk_cnt++;
                  if (out_reg !== 5'd8) $display("FAIL normal_first t=%0t: got %0d expected 8", $time, out_reg);
                  else pass_cnt++;
               end
               if ($time == 64'd3075 || $time == 64'd4575) begin
                  chk_cnt++;
                  if (out_reg !== 5'd12) $display("FAIL normal_second t=%0t: got %0d expected 12", $time, out_reg);
                  else pass_cnt++;
               end
               if ($time == 64'd5275) begin
                  chk_cnt++;
                  if (out_reg !== 5'd18) $display("FAIL normal_third: got %0d expected 18", out_reg);
                  else pass_cnt++;
               end
            end
         end
      join
   endtask

   task automatic test_saturation;
      cyc(1);
      pulse = 1'b1;
      cyc(40);
      pulse = 1'b0;
      cyc(LAT + 1);
      chk_cnt++;
      if (out_reg !== 5'd31) $display("FAIL saturation: got %0d expected 31", out_reg);
      else pass_cnt++;
      chk_cnt++;
      if (out_reg !== m_out) $display("FAIL saturation_model: got %0d expected %0d", out_reg, m_out);
      else pass_cnt++;
   endtask

   task automatic test_min_glitch;
      pulse = 1'b1;
      cyc(1);
      pulse = 1'b0;
      cyc(LAT + 2);
      chk_cnt++;
      if (out_reg !== 5'd1) $display("FAIL min_pulse: got %0d expected 1", out_reg);
      else pass_cnt++;
      #10 pulse = 1'b1;
      #20 pulse = 1'b0;
      cyc(LAT + 3);
      chk_cnt++;
      if (out_reg !== 5'd1) $display("FAIL glitch: got %0d expected 1", out_reg);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      pulse = 1'b1;
      cyc(5);
      chk_cnt++;
      if (out_reg !== 5'd1) $display("FAIL mid_before_reset: got %0d expected 1", out_reg);
      else pass_cnt++;
      a_reset = 1'b0;
      #1;
      chk_cnt++;
      if (out_reg !== 5'd0) $display("FAIL mid_reset_clear: got %0d expected 0", out_reg);
      else pass_cnt++;
      #29 a_reset = 1'b1;
      cyc(7);
      pulse = 1'b0;
      cyc(LAT + 1);
      chk_cnt++;
      if (out_reg !== 5'd7) $display("FAIL mid_remaining: got %0d expected 7", out_reg);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      pulse = 1'b1;
      cyc(3);
      pulse = 1'b0;
      cyc(1);
      pulse = 1'b1;
      cyc(LAT);
      chk_cnt++;
      if (out_reg !== 5'd3) $display("FAIL b2b_first: got %0d expected 3", out_reg);
      else pass_cnt++;
      cyc(4 - LAT);
      pulse = 1'b0;
      cyc(LAT + 1);
      chk_cnt++;
      if (out_reg !== 5'd4) $display("FAIL b2b_second: got %0d expected 4", out_reg);
      else pass_cnt++;
   endtask

   task automatic test_random;
      int unsigned w, g;
      logic [4:0]  e;
      for (int p = 0; p < 30; p++) begin
         w = $urandom_range(40, 1);
         g = $urandom_range(6, 1);
         e = (w > 31) ? 5'd31 : 5'(w);
         pulse = 1'b1;
         for (int i = 0; i < int'(w + g); i++) begin
            if (i == int'(w)) pulse = 1'b0;
            cyc(1);
            chk_cnt++;
            if (out_reg !== m_out) $display("FAIL random_model p=%0d i=%0d: got %0d expected %0d", p, i, out_reg, m_out);
            else pass_cnt++;
         end
         if (int'(g) > LAT) begin
            chk_cnt++;
            if (out_reg !== e) $display("FAIL random_width p=%0d w=%0d: got %0d expected %0d", p, w, out_reg, e);
            else pass_cnt++;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset;
      test_normal;
      test_saturation;
      test_min_glitch;
      test_reset_mid;
      test_back_to_back;
      test_random;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/top_hp.md
# top_hp

Pulse-width meter that measures, in SYS_CLK cycles, how long each high pulse on an asynchronous input PULSE lasts. It publishes the result on a 5-bit register output when the pulse ends. It is the top-level of the pulse-counter block and sits between an external pulse source and downstream logic that reads OUT_REG.

## Interface
- CNT_W, 5: width of the internal counter and of OUT_REG. The top level is fixed at 5; the parameter exists for internal reuse.
- SYS_CLK input 1: single system clock; all state updates on the rising edge.
- A_RESET input 1: reset, asynchronous assert, active-low. 0 clears all state immediately.
- PULSE input 1: asynchronous pulse to be measured; a pulse is any high interval.
- OUT_REG output CNT_W: width of the most recently completed high pulse, in cycles. Registered output.

## Operation
- **Input stage.** PULSE passes through the input stage (see Configuration) to give the sampled level p_s.
- **Edge detection.** A register p_d holds p_s from the previous cycle.
  - Rise: p_s=1, p_d=0.
  - Fall: p_s=0, p_d=1.
- **Counter cnt** (CNT_W bits), evaluated each cycle in this priority:
  - On rise: cnt <= 1.
  - On hold (p_s=1, p_d=1): cnt <= cnt+1, saturating at 2^CNT_W-1 (31). It never wraps.
  - On fall: OUT_REG <= cnt, then cnt <= 0.
  - When idle (both 0): cnt holds 0.
- **Result.** cnt equals the number of rising SYS_CLK edges at which p_s was 1 during the pulse. This is also the value loaded into OUT_REG.
- **OUT_REG** holds its value between falls. It changes only on a fall or on reset.
- **Boundary cases:**
  - A pulse sampled high on exactly one edge reports 1.
  - A pulse narrower than a clock period that is never sampled high is not seen, and OUT_REG is unchanged.
  - A pulse of 31 or more cycles reports 31.
  - A pulse still high at any instant leaves OUT_REG at the previous result.
  - Back-to-back pulses separated by one sampled-low cycle are each measured independently.
- **Reset (A_RESET=0), at any time including mid-pulse:**
  - Immediately clears cnt, p_d, the synchronizer flops and OUT_REG to 0.
  - The partial pulse is discarded.
  - After release, if PULSE is still high, it is treated as a new rise on the first sampled-high edge. Only the remaining portion is measured.

## Timing
- Reset values: OUT_REG=0, cnt=0, p_d=0, synchronizer stages=0.
- Reset is asynchronous on assertion. Release is sampled synchronously; the first active edge is the first SYS_CLK rise with A_RESET=1.
- With the synchronizer compiled in:
  - p_s lags PULSE by 2 cycles.
  - OUT_REG updates on the 3rd rising edge at which PULSE is sampled low after the pulse, counting the first such edge as #1.
- Without the synchronizer: OUT_REG updates on the 1st rising edge at which PULSE is sampled low.
- Measured width is identical in both builds. Only the latency differs.
- There is no handshake: a consumer samples OUT_REG at any time after the update edge.

## Configuration
- Macro TOP_HP_SYNC_EN.
- **Defined:** PULSE is passed through a 2-flop synchronizer (both flops reset to 0) before edge detection, giving p_s = second flop.
- **Undefined:** p_s = PULSE directly. The integrator guarantees PULSE is synchronous to SYS_CLK. Fall-to-OUT_REG latency is 0 extra cycles.

## Test plan
All scenarios use a 100 ns clock with first rising edge at 50 ns and A_RESET released at 100 ns.
- **Reset state:** hold A_RESET=0 for 100 ns -> OUT_REG=0 throughout; release -> OUT_REG stays 0 while PULSE=0.
- **Normal sequence:** PULSE high 200–1000, 1500–2700 and 3100–4900 ns.
  - OUT_REG=8 after the first pulse ends, 12 after the second, 18 after the third.
  - Each value is held until the next fall.
  - In the synchronizer build, the updates occur at 1250, 2950 and 5150 ns.
- **Saturation:** PULSE high for 40 cycles -> OUT_REG=31, with no wrap.
- **Minimum and glitch:**
  - A pulse sampled high on one edge -> OUT_REG=1.
  - A 20 ns pulse between edges -> OUT_REG unchanged.
- **Reset mid-pulse:** PULSE rises, and A_RESET is pulsed low for 30 ns after 5 cycles.
  - OUT_REG=0 immediately.
  - PULSE then stays high 7 more sampled edges and falls -> OUT_REG=7.
- **Back-to-back:** pulses of 3 and 4 cycles separated by 1 low cycle -> OUT_REG=3, then 4.
